// File: rtl/canvas_memory.sv
// Single-bit cell canvas: cleared by a full sweep, set by pixel draws, read back
// one cycle later by the display. Also keeps a live count of set cells.
module canvas_memory #(
   parameter int unsigned CELL_SHIFT = 3,
   parameter int unsigned COLS       = 80,
   parameter int unsigned ROWS       = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        draw_pixel_i,
   input  logic        clear_canvas_i,
   input  logic [9:0]  draw_x_i,
   input  logic [8:0]  draw_y_i,
   input  logic [9:0]  rd_x_i,
   input  logic [8:0]  rd_y_i,
   output logic        rd_cell_o,
   output logic        busy_o,
   output logic        draw_ack_o,
   output logic [12:0] live_count_o
);

   localparam int unsigned NumCells = COLS * ROWS;
   localparam int unsigned AW       = $clog2(NumCells);

   typedef enum logic [1:0] {StClear, StIdle, StCheck} state_e;

   state_e              state_q;
   logic [AW-1:0]       sweep_q;
   logic [AW-1:0]       chk_addr_q;
   logic [AW-1:0]       pend_addr_q;
   logic                pend_v_q;
   logic                draw_ack_q;
   logic                rd_cell_q;
   logic [12:0]         live_q;
   logic [NumCells-1:0] mem_q;

   logic          draw_ok;
   logic          rd_ok;
   logic [AW-1:0] draw_addr;
   logic [AW-1:0] rd_addr;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic          mem_wdata;

   function automatic logic in_range(input logic [9:0] x, input logic [8:0] y);
      return (32'(x) < (COLS << CELL_SHIFT)) && (32'(y) < (ROWS << CELL_SHIFT));
   endfunction

   function automatic logic [AW-1:0] cell_addr(input logic [9:0] x, input logic [8:0] y);
      return AW'((32'(y) >> CELL_SHIFT) * COLS + (32'(x) >> CELL_SHIFT));
   endfunction

   always_comb begin
      draw_ok   = draw_pixel_i && in_range(draw_x_i, draw_y_i);
      draw_addr = cell_addr(draw_x_i, draw_y_i);
      rd_ok     = in_range(rd_x_i, rd_y_i);
      rd_addr   = cell_addr(rd_x_i, rd_y_i);
      mem_we    = 1'b0;
      mem_waddr = sweep_q;
      mem_wdata = 1'b0;
      unique case (state_q)
         StClear: mem_we = 1'b1;
         StCheck: begin
            // Only write when the cell is not already set.
            mem_we    = ~mem_q[chk_addr_q];
            mem_waddr = chk_addr_q;
            mem_wdata = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StClear;
         sweep_q     <= '0;
         chk_addr_q  <= '0;
         pend_addr_q <= '0;
         pend_v_q    <= 1'b0;
         draw_ack_q  <= 1'b0;
         rd_cell_q   <= 1'b0;
         live_q      <= '0;
      end else begin
         draw_ack_q <= 1'b0;
         // Reads sample the pre-write array, masked while sweeping.
         rd_cell_q  <= rd_ok && (state_q != StClear) && mem_q[rd_addr];
         unique case (state_q)
            StClear: begin
               live_q <= '0;
               if (draw_ok) begin
                  pend_v_q    <= 1'b1;
                  pend_addr_q <= draw_addr;
               end
               if (clear_canvas_i) begin
                  sweep_q <= '0;
               end else if (sweep_q == AW'(NumCells - 1)) begin
                  sweep_q <= '0;
                  if (draw_ok || pend_v_q) begin
                     state_q    <= StCheck;
                     chk_addr_q <= draw_ok ? draw_addr : pend_addr_q;
                     pend_v_q   <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  sweep_q <= sweep_q + 1'b1;
               end
            end
            StIdle: begin
               if (clear_canvas_i) begin
                  state_q <= StClear;
                  sweep_q <= '0;
                  live_q  <= '0;
                  if (draw_ok) begin
                     pend_v_q    <= 1'b1;
                     pend_addr_q <= draw_addr;
                  end
               end else if (draw_ok) begin
                  state_q    <= StCheck;
                  chk_addr_q <= draw_addr;
               end
            end
            StCheck: begin
               draw_ack_q <= 1'b1;
               if (!mem_q[chk_addr_q] && (live_q != 13'(NumCells))) live_q <= live_q + 13'd1;
               if (clear_canvas_i) begin
                  state_q <= StClear;
                  sweep_q <= '0;
                  live_q  <= '0;
                  if (draw_ok) begin
                     pend_v_q    <= 1'b1;
                     pend_addr_q <= draw_addr;
                  end
               end else if (draw_ok || pend_v_q) begin
                  // Pending draw chains straight into another check.
                  chk_addr_q <= draw_ok ? draw_addr : pend_addr_q;
                  pend_v_q   <= 1'b0;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StClear;
         endcase
      end
   end

   assign busy_o       = (state_q == StClear);
   assign rd_cell_o    = rd_cell_q;
   assign draw_ack_o   = draw_ack_q;
   assign live_count_o = live_q;

endmodule

// File: tb/tb_canvas_memory.sv
// Directed bench for canvas_memory: reset sweep, draws, range limits, pending
// draws during sweeps, sweep restart.
module tb_canvas_memory;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        draw_pixel = 1'b0;
   logic        clear_canvas = 1'b0;
   logic [9:0]  draw_x = '0;
   logic [8:0]  draw_y = '0;
   logic [9:0]  rd_x = '0;
   logic [8:0]  rd_y = '0;
   logic        rd_cell;
   logic        busy;
   logic        draw_ack;
   logic [12:0] live_count;

   int errors = 0;
   int checks = 0;

   canvas_memory dut (
      .clk            (clk),
      .rst            (rst),
      .draw_pixel_i   (draw_pixel),
      .clear_canvas_i (clear_canvas),
      .draw_x_i       (draw_x),
      .draw_y_i       (draw_y),
      .rd_x_i         (rd_x),
      .rd_y_i         (rd_y),
      .rd_cell_o      (rd_cell),
      .busy_o         (busy),
      .draw_ack_o     (draw_ack),
      .live_count_o   (live_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic read_cell(input int x, input int y, output int v);
      rd_x = 10'(x);
      rd_y = 9'(y);
      @(negedge clk);
      v = int'(rd_cell);
   endtask

   // Returns negedges from the pulse to drawAck, or -1 if none within 10.
   task automatic do_draw(input int x, input int y, output int lat);
      draw_x     = 10'(x);
      draw_y     = 9'(y);
      draw_pixel = 1'b1;
      @(negedge clk);
      draw_pixel = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         if (draw_ack) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 10000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_ack(output int n);
      n = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (draw_ack) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int v;
      int lat;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_busy", int'(busy), 1);
      check_eq("rst_rd", int'(rd_cell), 0);
      check_eq("rst_ack", int'(draw_ack), 0);
      check_eq("rst_live", int'(live_count), 0);
      rst = 1'b0;
      count_busy(n);
      check_eq("init_sweep_len", n, 4800);
      read_cell(0, 0, v);
      check_eq("init_rd_0_0", v, 0);
      read_cell(639, 479, v);
      check_eq("init_rd_639_479", v, 0);
      check_eq("init_live", int'(live_count), 0);

      // Draw (17,9) -> cell 82, with the read port watching the same cell
      rd_x = 10'd17;
      rd_y = 9'd9;
      draw_x = 10'd17;
      draw_y = 9'd9;
      draw_pixel = 1'b1;
      @(negedge clk);
      draw_pixel = 1'b0;
      check_eq("d1_ack_c1", int'(draw_ack), 0);
      check_eq("d1_rd_c1", int'(rd_cell), 0);
      @(negedge clk);
      check_eq("d1_ack_c2", int'(draw_ack), 1);
      check_eq("d1_rd_prewrite", int'(rd_cell), 0);
      @(negedge clk);
      check_eq("d1_ack_c3", int'(draw_ack), 0);
      check_eq("d1_rd_visible", int'(rd_cell), 1);
      check_eq("d1_live", int'(live_count), 1);
      read_cell(16, 8, v);
      check_eq("d1_rd_16_8", v, 1);
      read_cell(23, 15, v);
      check_eq("d1_rd_23_15", v, 1);
      read_cell(24, 8, v);
      check_eq("d1_rd_24_8", v, 0);
      read_cell(16, 16, v);
      check_eq("d1_rd_16_16", v, 0);

      // Same draw again: ack but no count change
      do_draw(17, 9, lat);
      check_eq("d2_ack_lat", lat, 2);
      check_eq("d2_live", int'(live_count), 1);

      // Corner cell 4799, then out-of-range draws
      do_draw(639, 479, lat);
      check_eq("corner_ack_lat", lat, 2);
      check_eq("corner_live", int'(live_count), 2);
      read_cell(639, 479, v);
      check_eq("corner_rd", v, 1);
      do_draw(640, 0, lat);
      check_eq("oor_x_ack", lat, -1);
      check_eq("oor_x_live", int'(live_count), 2);
      do_draw(0, 480, lat);
      check_eq("oor_y_ack", lat, -1);
      check_eq("oor_y_live", int'(live_count), 2);
      read_cell(640, 0, v);
      check_eq("oor_rd", v, 0);

      // Three more cells -> 5 set
      do_draw(100, 100, lat);
      do_draw(300, 50, lat);
      do_draw(8, 0, lat);
      check_eq("five_live", int'(live_count), 5);

      // Clear and draw (0,0) in the same cycle
      draw_x = 10'd0;
      draw_y = 9'd0;
      draw_pixel = 1'b1;
      clear_canvas = 1'b1;
      @(negedge clk);
      draw_pixel = 1'b0;
      clear_canvas = 1'b0;
      check_eq("cd_live_zero", int'(live_count), 0);
      count_busy(n);
      check_eq("cd_sweep_len", n, 4800);
      wait_ack(n);
      check_eq("cd_ack_after", n, 1);
      check_eq("cd_live", int'(live_count), 1);
      read_cell(0, 0, v);
      check_eq("cd_rd_0_0", v, 1);
      read_cell(8, 0, v);
      check_eq("cd_rd_8_0", v, 0);
      read_cell(17, 9, v);
      check_eq("cd_rd_17_9", v, 0);
      read_cell(639, 479, v);
      check_eq("cd_rd_639_479", v, 0);

      // Pending draws during a sweep, with a restart at address 2000
      do_draw(639, 479, lat);
      check_eq("pre_live", int'(live_count), 2);
      rd_x = 10'd639;
      rd_y = 9'd479;
      clear_canvas = 1'b1;
      @(negedge clk);
      clear_canvas = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (k == 100) begin
            check_eq("sweep_rd_masked", int'(rd_cell), 0);
            check_eq("sweep_busy", int'(busy), 1);
            draw_x = 10'd16;
            draw_y = 9'd0;
            draw_pixel = 1'b1;
         end else if (k == 500) begin
            draw_x = 10'd24;
            draw_y = 9'd0;
            draw_pixel = 1'b1;
         end else begin
            draw_pixel = 1'b0;
         end
         @(negedge clk);
      end
      draw_pixel = 1'b0;
      clear_canvas = 1'b1;
      @(negedge clk);
      clear_canvas = 1'b0;
      n = 0;
      while (busy && n < 10000) begin
         if (n == 10) begin
            draw_x = 10'd40;
            draw_y = 9'd16;
            draw_pixel = 1'b1;
         end else begin
            draw_pixel = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      draw_pixel = 1'b0;
      check_eq("restart_sweep_len", n, 4800);
      wait_ack(n);
      check_eq("pend_ack", n, 1);
      check_eq("pend_live", int'(live_count), 1);
      read_cell(40, 16, v);
      check_eq("pend_rd_last", v, 1);
      read_cell(16, 0, v);
      check_eq("pend_rd_first", v, 0);
      read_cell(24, 0, v);
      check_eq("pend_rd_second", v, 0);

      // Reset while idle returns to the sweep state
      rst = 1'b1;
      @(negedge clk);
      check_eq("rerst_busy", int'(busy), 1);
      check_eq("rerst_live", int'(live_count), 0);
      check_eq("rerst_rd", int'(rd_cell), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
